// File: rtl/adc_serial_sampler_if.sv
// adc_serial_sampler_if
//   Signal bundle between the ADC sampler and its neighbours (serial ADC, APB ADC register slave).
//   sample_enable  APB slave -> sampler : 1 = run periodic conversions
//   adc_sdo        ADC -> sampler       : serial data, MSB first, changes on SCLK falling edge
//   adc_cs_n       sampler -> ADC       : chip select, active-low
//   adc_sclk       sampler -> ADC       : serial clock, idles high
//   ADC_DATA       sampler -> APB slave : last completed 12-bit result
//   adc_valid      sampler -> APB slave : 1-cycle strobe, ADC_DATA updated in the same cycle
//   adc_overrun    sampler -> APB slave : sticky, period expired during a conversion
//   modport master : the sampler itself
//   modport slave  : everything around the sampler
interface adc_serial_sampler_if;
    logic        sample_enable;
    logic        adc_sdo;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic [11:0] ADC_DATA;
    logic        adc_valid;
    logic        adc_overrun;

    modport master (
        input  sample_enable,
        input  adc_sdo,
        output adc_cs_n,
        output adc_sclk,
        output ADC_DATA,
        output adc_valid,
        output adc_overrun
    );

    modport slave (
        output sample_enable,
        output adc_sdo,
        input  adc_cs_n,
        input  adc_sclk,
        input  ADC_DATA,
        input  adc_valid,
        input  adc_overrun
    );
endinterface

// File: rtl/adc_serial_sampler.sv
// adc_serial_sampler
//   Drives a 3-wire serial SAR ADC (CS_n/SCLK/SDO). While sample_enable is high a conversion is
//   started every SAMPLE_PERIOD PCLK cycles; each CONV_BITS-bit frame is de-serialised and its
//   last 12 bits are presented on ADC_DATA with a one-cycle adc_valid strobe.
//   Optional feature macro ADC_AVG4_EN: when defined, four consecutive results are averaged and
//   only every 4th frame produces a strobe; when undefined every frame is reported (raw mode).
// Parameters
//   CLK_DIV        PCLK cycles per SCLK half-period (>=1)
//   CONV_BITS      SCLK cycles per frame (>=12)
//   SAMPLE_PERIOD  PCLK cycles between conversion starts (>=2)
// Ports
//   PCLK           clock, all state on the rising edge
//   PRESETn        asynchronous active-low reset
//   io_adc         adc_serial_sampler_if master modport (see interface file)
module adc_serial_sampler #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned CONV_BITS     = 16,
    parameter int unsigned SAMPLE_PERIOD = 1000
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    adc_serial_sampler_if.master io_adc
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(CONV_BITS + 1);
    localparam int unsigned TMR_W = $clog2(SAMPLE_PERIOD);

    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_TC = BIT_W'(CONV_BITS - 1);
    localparam logic [TMR_W-1:0] TMR_TC = TMR_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StConv, StDone, StWait} state_e;

    state_e               r_state;
    logic [DIV_W-1:0]     r_div;
    logic [BIT_W-1:0]     r_bits;     // rising SCLK edges taken in the current frame
    logic [TMR_W-1:0]     r_timer;
    logic [CONV_BITS-1:0] r_shift;
    logic                 r_pending;  // period expired mid-frame: restart right after DONE
    logic                 r_cs_n;
    logic                 r_sclk;
    logic [11:0]          r_data;
    logic                 r_valid;
    logic                 r_overrun;
`ifdef ADC_AVG4_EN
    logic [13:0]          r_sum;
    logic [1:0]           r_phase;
    logic [13:0]          w_sum_nxt;
`endif

    logic                 w_tmr_tc;
    logic                 w_div_tc;
    logic                 w_start;
    logic [CONV_BITS-1:0] w_shift_nxt;
    logic [11:0]          w_raw;
    logic                 w_unused_shift_msb;

    assign w_tmr_tc    = (r_timer == TMR_TC);
    assign w_div_tc    = (r_div == DIV_TC);
    assign w_shift_nxt = {r_shift[CONV_BITS-2:0], io_adc.adc_sdo};
    // The frame ends on the edge that takes the last bit, so the result comes from w_shift_nxt.
    assign w_raw       = w_shift_nxt[11:0];
    assign w_unused_shift_msb = r_shift[CONV_BITS-1];
`ifdef ADC_AVG4_EN
    assign w_sum_nxt   = r_sum + 14'(w_raw);
`endif

    assign w_start = io_adc.sample_enable &&
                     ((r_state == StIdle) ||
                      (r_state == StDone && (r_pending || w_tmr_tc)) ||
                      (r_state == StWait && w_tmr_tc));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= StIdle;
            r_div     <= '0;
            r_bits    <= '0;
            r_timer   <= '0;
            r_shift   <= '0;
            r_pending <= 1'b0;
            r_cs_n    <= 1'b1;
            r_sclk    <= 1'b1;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
`ifdef ADC_AVG4_EN
            r_sum     <= '0;
            r_phase   <= '0;
`endif
        end else begin
            r_valid <= 1'b0;

            if (r_state == StIdle) begin
                r_timer <= '0;
            end else begin
                r_timer <= w_tmr_tc ? '0 : r_timer + 1'b1;
            end

            if (w_tmr_tc && (r_state == StConv || r_state == StDone)) begin
                r_overrun <= 1'b1;
            end

            unique case (r_state)
                StIdle: begin
                    r_pending <= 1'b0;
                    if (!io_adc.sample_enable) begin
                        r_overrun <= 1'b0;
                    end
`ifdef ADC_AVG4_EN
                    r_sum   <= '0;
                    r_phase <= '0;
`endif
                end
                StConv: begin
                    if (w_tmr_tc) begin
                        r_pending <= 1'b1;
                    end
                    r_div <= w_div_tc ? '0 : r_div + 1'b1;
                    if (w_div_tc) begin
                        r_sclk <= ~r_sclk;
                        // SCLK low -> high: take one data bit
                        if (!r_sclk) begin
                            r_shift <= w_shift_nxt;
                            r_bits  <= r_bits + 1'b1;
                            if (r_bits == BIT_TC) begin
                                r_state <= StDone;
                                r_cs_n  <= 1'b1;
`ifdef ADC_AVG4_EN
                                if (r_phase == 2'd3) begin
                                    r_data  <= w_sum_nxt[13:2];
                                    r_valid <= 1'b1;
                                    r_sum   <= '0;
                                end else begin
                                    r_sum   <= w_sum_nxt;
                                end
                                r_phase <= r_phase + 1'b1;
`else
                                r_data  <= w_raw;
                                r_valid <= 1'b1;
`endif
                            end
                        end
                    end
                end
                StDone: begin
                    r_state <= io_adc.sample_enable ? StWait : StIdle;
                end
                StWait: begin
                    if (!io_adc.sample_enable) begin
                        r_state <= StIdle;
                    end
                end
            endcase

            // Conversion entry overrides the per-state updates above.
            if (w_start) begin
                r_state   <= StConv;
                r_cs_n    <= 1'b0;
                r_sclk    <= 1'b1;
                r_div     <= '0;
                r_bits    <= '0;
                r_timer   <= '0;
                r_pending <= 1'b0;
            end
        end
    end

    assign io_adc.adc_cs_n    = r_cs_n;
    assign io_adc.adc_sclk    = r_sclk;
    assign io_adc.ADC_DATA    = r_data;
    assign io_adc.adc_valid   = r_valid;
    assign io_adc.adc_overrun = r_overrun;
endmodule

// File: tb/tb_adc_serial_sampler.sv
// Testbench for adc_serial_sampler. Instance A: CLK_DIV=2, CONV_BITS=16, SAMPLE_PERIOD=100 with a
// behavioural ADC. Instance B: same but SAMPLE_PERIOD=50 (overrun), ADC data tied high.
module tb_adc_serial_sampler;
    logic PCLK = 1'b0;
    logic PRESETn;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    adc_serial_sampler_if ifa ();
    adc_serial_sampler_if ifb ();

    adc_serial_sampler #(.CLK_DIV(2), .CONV_BITS(16), .SAMPLE_PERIOD(100)) u_dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .io_adc (ifa)
    );

    adc_serial_sampler #(.CLK_DIV(2), .CONV_BITS(16), .SAMPLE_PERIOD(50)) u_dut_ovr (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .io_adc (ifb)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Behavioural ADC for instance A: one queued frame per CS_n fall, MSB out on each SCLK fall.
    logic [15:0] frames_a[$];
    logic [15:0] adc_cur = 16'h0;
    int          adc_idx = 0;
    logic        adc_sdo_a = 1'b0;
    assign ifa.adc_sdo = adc_sdo_a;
    assign ifb.adc_sdo = 1'b1;

    always @(negedge ifa.adc_cs_n) begin
        adc_cur = (frames_a.size() != 0) ? frames_a.pop_front() : 16'h0;
        adc_idx = 15;
    end

    always @(negedge ifa.adc_sclk) begin
        if (!ifa.adc_cs_n && adc_idx >= 0) begin
            adc_sdo_a = adc_cur[adc_idx];
            adc_idx   = adc_idx - 1;
        end
    end

    // Scoreboard queues and monitor state, index 0 = A, 1 = B.
    logic [11:0] exp_a[$];
    logic [11:0] exp_b[$];
    int          falls_a[$];
    int          falls_b[$];
    logic        prev_cs[2];
    logic        prev_sclk[2];
    int          lowcnt[2];
    int          rises[2];
    int          fall_cyc[2];
    int          nfalls[2];
`ifdef ADC_AVG4_EN
    int          acc_sum[2];
    int          acc_n[2];
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_add(input int d, input logic [11:0] v);
        if (d == 0) exp_a.push_back(v);
        else exp_b.push_back(v);
    endtask

    // Expected response for one raw frame result; averages in groups of four when enabled.
    task automatic sb_push(input int d, input logic [11:0] raw);
`ifdef ADC_AVG4_EN
        acc_sum[d] += int'(raw);
        acc_n[d]++;
        if (acc_n[d] == 4) begin
            sb_add(d, 12'(acc_sum[d] >> 2));
            acc_sum[d] = 0;
            acc_n[d]   = 0;
        end
`else
        sb_add(d, raw);
`endif
    endtask

    task automatic end_run(input int d);
`ifdef ADC_AVG4_EN
        acc_sum[d] = 0;
        acc_n[d]   = 0;
`else
        if (d < 0) $display("bad index");
`endif
    endtask

    task automatic mon(input int d, input logic rst_n, input logic cs_n, input logic sclk,
                       input logic valid, input logic [11:0] data);
        logic [11:0] e;
        if (!rst_n) begin
            prev_cs[d]   = 1'b1;
            prev_sclk[d] = 1'b1;
            lowcnt[d]    = 0;
            rises[d]     = 0;
            return;
        end
        if (valid) begin
            chk("valid_latency", 32'(cyc - fall_cyc[d]), 32'd64);
            if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid dut%0d: got ADC_DATA 0x%0h, want no strobe", d, data);
            end else begin
                e = (d == 0) ? exp_a.pop_front() : exp_b.pop_front();
                chk("adc_data", 32'(data), 32'(e));
            end
        end
        if (prev_cs[d] && !cs_n) begin
            fall_cyc[d] = cyc;
            lowcnt[d]   = 0;
            rises[d]    = 0;
            nfalls[d]++;
            if (d == 0) falls_a.push_back(cyc);
            else falls_b.push_back(cyc);
        end
        if (!cs_n) lowcnt[d]++;
        if (!prev_cs[d] && sclk && !prev_sclk[d]) rises[d]++;
        if (!prev_cs[d] && cs_n) begin
            chk("cs_low_cycles", 32'(lowcnt[d]), 32'd64);
            chk("sclk_rises", 32'(rises[d]), 32'd16);
        end
        prev_cs[d]   = cs_n;
        prev_sclk[d] = sclk;
    endtask

    always @(posedge PCLK) begin
        #1;
        mon(0, PRESETn, ifa.adc_cs_n, ifa.adc_sclk, ifa.adc_valid, ifa.ADC_DATA);
        mon(1, PRESETn, ifb.adc_cs_n, ifb.adc_sclk, ifb.adc_valid, ifb.ADC_DATA);
    end

    task automatic wait_fall(input int d, input int limit);
        int start;
        start = nfalls[d];
        for (int i = 0; i < limit; i++) begin
            @(negedge PCLK);
            if (nfalls[d] != start) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL cs_fall_timeout dut%0d: got no CS_n fall, want one within %0d", d, limit);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs_n"}, 32'(ifa.adc_cs_n), 32'd1);
        chk({tag, "_sclk"}, 32'(ifa.adc_sclk), 32'd1);
        chk({tag, "_data"}, 32'(ifa.ADC_DATA), 32'd0);
        chk({tag, "_valid"}, 32'(ifa.adc_valid), 32'd0);
        chk({tag, "_overrun"}, 32'(ifa.adc_overrun), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        logic [15:0] fr;
        for (int i = 0; i < 2; i++) begin
            prev_cs[i] = 1'b1; prev_sclk[i] = 1'b1; lowcnt[i] = 0; rises[i] = 0;
            fall_cyc[i] = 0; nfalls[i] = 0;
`ifdef ADC_AVG4_EN
            acc_sum[i] = 0; acc_n[i] = 0;
`endif
        end
        // 1: reset with sample_enable high
        PRESETn = 1'b0;
        ifa.sample_enable = 1'b1;
        ifb.sample_enable = 1'b0;
        repeat (3) @(negedge PCLK);
        chk_reset_outputs("rst");
        chk("rst_b_cs_n", 32'(ifb.adc_cs_n), 32'd1);

        // 2: single frame 0x0ABC
        frames_a.push_back(16'h0ABC);
        sb_push(0, 12'hABC);
        PRESETn = 1'b1;
        wait_fall(0, 10);
        ifa.sample_enable = 1'b0;
        repeat (120) @(negedge PCLK);
        end_run(0);
        chk("single_falls", 32'(nfalls[0]), 32'd1);
        chk("single_cs_idle", 32'(ifa.adc_cs_n), 32'd1);
        chk("single_drained", 32'(exp_a.size()), 32'd0);

        // 3: periodic, enable held 1000 cycles
        falls_a.delete();
        for (int i = 0; i < 10; i++) begin
            fr = 16'hF000 | 16'((i + 1) * 16'h0111);
            frames_a.push_back(fr);
            sb_push(0, 12'((i + 1) * 12'h111));
        end
        ifa.sample_enable = 1'b1;
        repeat (1000) @(negedge PCLK);
        chk("periodic_overrun", 32'(ifa.adc_overrun), 32'd0);
        ifa.sample_enable = 1'b0;
        repeat (150) @(negedge PCLK);
        end_run(0);
        chk("periodic_falls", 32'(falls_a.size()), 32'd10);
        for (int i = 1; i < falls_a.size(); i++) begin
            chk("periodic_spacing", 32'(falls_a[i] - falls_a[i-1]), 32'd100);
        end
        chk("periodic_drained", 32'(exp_a.size()), 32'd0);

        // 5a: disable at cycle 30 of CS_n low
        frames_a.push_back(16'h0555);
        sb_push(0, 12'h555);
        f0 = nfalls[0];
        ifa.sample_enable = 1'b1;
        wait_fall(0, 10);
        repeat (30) @(negedge PCLK);
        ifa.sample_enable = 1'b0;
        repeat (120) @(negedge PCLK);
        end_run(0);
        chk("disable_falls", 32'(nfalls[0] - f0), 32'd1);
        chk("disable_cs_idle", 32'(ifa.adc_cs_n), 32'd1);
        chk("disable_drained", 32'(exp_a.size()), 32'd0);

        // 5b: reset at cycle 30 of CS_n low, partial frame discarded
        frames_a.push_back(16'h0F0F);
        f0 = nfalls[0];
        ifa.sample_enable = 1'b1;
        wait_fall(0, 10);
        repeat (30) @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        ifa.sample_enable = 1'b0;
        repeat (5) @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (100) @(negedge PCLK);
        end_run(0);
        chk("midrst_falls", 32'(nfalls[0] - f0), 32'd1);
        chk("midrst_data", 32'(ifa.ADC_DATA), 32'd0);
        chk("midrst_cs_idle", 32'(ifa.adc_cs_n), 32'd1);

        // 4: overrun on instance B (period 50 < 64-cycle frame)
        falls_b.delete();
        for (int i = 0; i < 3; i++) sb_push(1, 12'hFFF);
        ifb.sample_enable = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge PCLK);
            if (i == 20) chk("ovr_before", 32'(ifb.adc_overrun), 32'd0);
            if (i == 100) chk("ovr_set", 32'(ifb.adc_overrun), 32'd1);
        end
        ifb.sample_enable = 1'b0;
        repeat (100) @(negedge PCLK);
        end_run(1);
        chk("ovr_falls", 32'(falls_b.size()), 32'd3);
        for (int i = 1; i < falls_b.size(); i++) begin
            chk("ovr_spacing", 32'(falls_b[i] - falls_b[i-1]), 32'd65);
        end
        chk("ovr_cleared", 32'(ifb.adc_overrun), 32'd0);
        chk("ovr_drained", 32'(exp_b.size()), 32'd0);

        // 6: four frames, averaged result when averaging is built in
        frames_a.push_back(16'h0100);
        frames_a.push_back(16'h0200);
        frames_a.push_back(16'h0300);
        frames_a.push_back(16'h0403);
`ifdef ADC_AVG4_EN
        sb_add(0, 12'h280);
`else
        sb_push(0, 12'h100);
        sb_push(0, 12'h200);
        sb_push(0, 12'h300);
        sb_push(0, 12'h403);
`endif
        f0 = nfalls[0];
        ifa.sample_enable = 1'b1;
        repeat (350) @(negedge PCLK);
        ifa.sample_enable = 1'b0;
        repeat (120) @(negedge PCLK);
        end_run(0);
        chk("avg_falls", 32'(nfalls[0] - f0), 32'd4);
        chk("avg_drained", 32'(exp_a.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
